// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath stages: word width, word type and
// the state encoding used by the sequential reduction stage.
package rsa_pkg;

  localparam int RSA_WIDTH = 256;

  typedef logic [RSA_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_reduce_process_if.sv
// Operand/result bundle of the modular-reduction stage. The master side is the
// upstream (power) stage or a testbench; the slave side is the reduction stage.
interface mod_reduce_process_if #(
  parameter int WIDTH = rsa_pkg::RSA_WIDTH
);

  // in_rdy qualifies data/modulus and is only looked at while the stage is
  // idle; out_rdy is a single-cycle pulse during which out (and div_err) are
  // valid. There is no back-pressure: the consumer must take the result then.
  logic             in_rdy;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] out;
  logic             out_rdy;
  logic             busy;
  logic             div_err;

  modport master (
    output in_rdy, data, modulus,
    input  out, out_rdy, busy, div_err
  );

  modport slave (
    input  in_rdy, data, modulus,
    output out, out_rdy, busy, div_err
  );

endinterface

// File: rtl/mod_sub_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits. Purely combinational.
module mod_sub_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] rem_next
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] n_ext;

  assign t     = {rem, bit_in};
  assign n_ext = {1'b0, n};

  // Compare/subtract at WIDTH+1 bits; either result is below n, so it fits WIDTH.
  assign rem_next = (t >= n_ext) ? WIDTH'(t - n_ext) : WIDTH'(t);

endmodule

// File: rtl/mod_reduce_process.sv
// Sequential modular reduction (data mod modulus) by restoring shift-subtract,
// one dividend bit per clock, fixed latency of WIDTH cycles after capture.
module mod_reduce_process
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  mod_reduce_process_if.slave  bus,
  output state_t               dbg_state
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q;
  logic [WIDTH-1:0]   nreg_q;
  logic [WIDTH-1:0]   rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   out_q;
  logic               out_rdy_q;
  logic               div_err_q;
  logic [WIDTH-1:0]   rem_next;
  logic               accept;
  logic               zero_mod;
  logic               last_step;

  // The partial remainder always stays below n; the extra top bit of the
  // shifted value only exists inside the step.
  mod_sub_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .bit_in   (shreg_q[WIDTH-1]),
    .n        (nreg_q),
    .rem_next (rem_next)
  );

  assign zero_mod = (bus.modulus == '0);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_rdy) begin
          accept  = 1'b1;
          state_d = zero_mod ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          last_step = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q   <= '0;
      nreg_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      out_rdy_q <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      out_rdy_q <= 1'b0;
      if (accept) begin
        shreg_q   <= bus.data;
        nreg_q    <= bus.modulus;
        rem_q     <= '0;
        cnt_q     <= '0;
        div_err_q <= zero_mod;
        if (zero_mod) begin
          out_q     <= bus.data;
          out_rdy_q <= 1'b1;
        end
      end else if (state_q == ST_RUN) begin
        rem_q   <= rem_next;
        shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
        cnt_q   <= cnt_q + CNT_W'(1);
        if (last_step) begin
          out_q     <= rem_next;
          out_rdy_q <= 1'b1;
        end
      end
    end
  end

  assign bus.out     = out_q;
  assign bus.out_rdy = out_rdy_q;
  assign bus.div_err = div_err_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: doc/mod_reduce_process.md
Name: mod_reduce_process

Overview:
- Sequential modular-reduction stage placed directly downstream of the power stage.
- Takes the 256-bit power result and a modulus n, and produces result mod n.
- Uses restoring shift-subtract division, one dividend bit per clock, with fixed latency.
- Uses the same in_rdy/out_rdy style as the power stage, so the power stage's out/out_rdy connect straight to data/in_rdy.

Parameters:
- WIDTH, 256, operand and result width in bits. Must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset; 0 clears all state immediately
- in_rdy  input  1  operands valid; sampled only in IDLE
- data  input  WIDTH  dividend (the power-stage result)
- modulus  input  WIDTH  divisor n
- out  output  WIDTH  remainder data mod n; registered
- out_rdy  output  1  one-cycle pulse; out is valid while it is high
- busy  output  1  high in RUN and DONE
- div_err  output  1  high with out_rdy when modulus == 0; sticky until the next accept

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; out=0, out_rdy=0, busy=0, div_err=0.
  - Internal remainder, dividend shift register and counter all cleared.
  - Reset mid-RUN abandons the operation; no out_rdy is produced for it.
- States: IDLE, RUN, DONE. Encoding lives in the package.
- IDLE:
  - On an edge with in_rdy=1, capture data into shreg and modulus into nreg; clear rem (WIDTH+1 bits) and cnt; clear div_err.
  - If modulus==0: out<=data, div_err<=1, out_rdy<=1, go to DONE.
  - Otherwise go to RUN.
  - With in_rdy=0, hold. out keeps its last value.
- RUN, each edge:
  - t = {rem[WIDTH-1:0], shreg[WIDTH-1]}.
  - If t ≥ {1'b0, nreg}, then rem <= t − nreg; else rem <= t.
  - shreg <= shreg << 1; cnt <= cnt+1.
  - On the edge where cnt == WIDTH−1: out <= final rem[WIDTH-1:0], out_rdy <= 1, go to DONE.
- DONE: one cycle. On the next edge out_rdy <= 0 and state goes to IDLE.
- Latency:
  - Capture at edge k → out_rdy high after edge k+WIDTH, low after edge k+WIDTH+1.
  - Earliest next accept is at edge k+WIDTH+2.
  - Zero-modulus path: out_rdy high after edge k.
- in_rdy during RUN or DONE is ignored; no queuing. Upstream must hold or re-present.
- Width rules:
  - rem is WIDTH+1 bits, so the shifted value never overflows.
  - Compare and subtract are done at WIDTH+1 bits; the result always fits in WIDTH bits.
  - cnt width is $clog2(WIDTH+1).
- Boundary conditions:
  - data < modulus → out=data.
  - modulus == 1 → out=0.
  - data == modulus → out=0.
  - Operands are captured, so later changes to data/modulus do not affect an operation in flight.

Decomposition:
- Shared package rsa_pkg:
  - RSA_WIDTH=256.
  - State enum/localparams ST_IDLE, ST_RUN, ST_DONE.
  - Common typedef for the 256-bit word.
- One natural sub-module, mod_sub_step: a combinational one-bit shift/compare/subtract (inputs rem, bit_in, n; output rem_next).
  - Reusable by a later Montgomery/modmul stage.
- Everything else (FSM, counter, registers) stays in the top.

Test Plan:
- Reset, then data=1000, modulus=7, in_rdy pulse → out=6, div_err=0, out_rdy high for exactly 1 cycle, 256 edges after capture; busy high in between.
- data=5, modulus=9 → out=5. Then data=2^256−1, modulus=2^256−1 → out=0. Then data=2^256−1, modulus=2^255 → out=2^255−1.
- modulus=0, data=0x1234 → next cycle out=0x1234, div_err=1, out_rdy pulse. A following valid op (data=10, modulus=3) clears div_err and gives out=1.
- Start op data=100, modulus=13. Drive in_rdy with data=50, modulus=7 during RUN and in DONE → out=9 only; second op ignored; no extra out_rdy.
- Assert reset=0 asynchronously (between edges) at RUN cycle 100 → outputs clear immediately, no out_rdy. After release, op data=77, modulus=10 → out=7.
- Back-to-back with in_rdy held high: data=2^200+3, modulus=2^100 → out=3; next accept occurs at edge k+258. Random regression of 1000 ops is checked against a reference model using %.
